// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised multi-read-port register file.
package regfile_pkg;

   typedef enum logic [0:0] {RF_CLEAR, RF_RUN} rf_state_t;

   localparam int RF_WIDTH_DEF    = 32;
   localparam int RF_DEPTH_DEF    = 32;
   localparam int RF_NRD_DEF      = 2;
   localparam int RF_ZERO_REG_DEF = 1;

   function automatic int rf_aw(int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear/run sequencer: sweeps zeros through every entry after reset or a clr request.
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int DEPTH = RF_DEPTH_DEF,
   localparam int AW   = rf_aw(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   output logic          ready,
   output logic          sweep_we,
   output logic [AW-1:0] sweep_addr
);

   rf_state_t     state, state_nxt;
   logic [AW-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RF_CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // DEPTH is a power of two, so the counter wraps to 0 naturally on the last entry.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         RF_CLEAR: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == AW'(DEPTH - 1))
               state_nxt = RF_RUN;
         end
         RF_RUN: begin
            cnt_nxt = '0;
            if (clr)
               state_nxt = RF_CLEAR;
         end
         default: begin
            state_nxt = RF_CLEAR;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign ready      = (state == RF_RUN);
   assign sweep_we   = (state == RF_CLEAR);
   assign sweep_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with NRD combinational read lanes, hardware clear sweep and
// a registered debug port. Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int WIDTH    = RF_WIDTH_DEF,
   parameter int DEPTH    = RF_DEPTH_DEF,
   parameter int NRD      = RF_NRD_DEF,
   parameter int ZERO_REG = RF_ZERO_REG_DEF,
   localparam int AW      = rf_aw(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NRD*AW-1:0]    ra,
   output logic [NRD*WIDTH-1:0] rd,
   input  logic                 we,
   input  logic [AW-1:0]        wa,
   input  logic [WIDTH-1:0]     wd,
   input  logic                 clr,
   output logic                 ready,
   input  logic [AW-1:0]        dbg_addr,
   output logic [WIDTH-1:0]     dbg_data
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic             sweep_we;
   logic [AW-1:0]    sweep_addr;
   logic             wr_ok;

   regfile_clear_fsm #(.DEPTH(DEPTH)) u_clear_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .ready      (ready),
      .sweep_we   (sweep_we),
      .sweep_addr (sweep_addr)
   );

   // A write survives only in RUN, without a competing clr, and not to a hardwired zero entry.
   assign wr_ok = ready && we && !clr && !((ZERO_REG != 0) && (wa == '0));

   always_ff @(posedge clk) begin
      if (sweep_we)
         mem[sweep_addr] <= '0;
      else if (wr_ok)
         mem[wa] <= wd;
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]    lane_addr;
      logic [WIDTH-1:0] lane_data;

      assign lane_addr = ra[k*AW +: AW];

      always_comb begin
         lane_data = mem[lane_addr];
         if ((ZERO_REG != 0) && (lane_addr == '0))
            lane_data = '0;
`ifdef REGFILE_BYPASS_EN
         if (wr_ok && (lane_addr == wa))
            lane_data = wd;
`endif
         if (!ready)
            lane_data = '0;
      end

      assign rd[k*WIDTH +: WIDTH] = lane_data;
   end

   // Debug view follows the array every cycle, so it shows a sweep in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         dbg_data <= '0;
      else if ((ZERO_REG != 0) && (dbg_addr == '0))
         dbg_data <= '0;
      else
         dbg_data <= mem[dbg_addr];
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: a default 32x32/2-lane file and a 16x8/4-lane file without zero entry.
module tb_regfile_mp;

   logic        clk;
   logic        rst_n;

   logic        in_we  [2];
   logic        in_clr [2];
   logic [31:0] in_wa  [2];
   logic [31:0] in_wd  [2];
   logic [31:0] in_dbg [2];
   logic [31:0] in_ra  [2][4];

   logic [63:0] rd0;
   logic [31:0] rd2;
   logic [31:0] dbg0;
   logic [7:0]  dbg2;
   logic        ready0, ready2;

   int checks   = 0;
   int failures = 0;

   // Reference model: contents, remaining sweep entries and the expected debug register.
   int          dep [2] = '{32, 16};
   bit          zr  [2] = '{1'b1, 1'b0};
   logic [31:0] m_mem [2][32];
   bit          m_ready   [2];
   int          clear_left[2];
   bit          mem_known [2];
   logic [31:0] m_dbg     [2];
   bit          dbg_valid [2];

   typedef struct {
      bit          we;
      int          wa;
      logic [31:0] wd;
      int          ra0;
      int          ra1;
      logic [31:0] e0;
      logic [31:0] e1;
   } vec_t;
   vec_t vecs[6];

   regfile_mp dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ra       ({in_ra[0][1][4:0], in_ra[0][0][4:0]}),
      .rd       (rd0),
      .we       (in_we[0]),
      .wa       (in_wa[0][4:0]),
      .wd       (in_wd[0]),
      .clr      (in_clr[0]),
      .ready    (ready0),
      .dbg_addr (in_dbg[0][4:0]),
      .dbg_data (dbg0)
   );

   regfile_mp #(.WIDTH(8), .DEPTH(16), .NRD(4), .ZERO_REG(0)) dut2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .ra       ({in_ra[1][3][3:0], in_ra[1][2][3:0], in_ra[1][1][3:0], in_ra[1][0][3:0]}),
      .rd       (rd2),
      .we       (in_we[1]),
      .wa       (in_wa[1][3:0]),
      .wd       (in_wd[1][7:0]),
      .clr      (in_clr[1]),
      .ready    (ready2),
      .dbg_addr (in_dbg[1][3:0]),
      .dbg_data (dbg2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input int d, input bit we, input int wa, input logic [31:0] wd);
      in_we[d] = we;
      in_wa[d] = wa;
      in_wd[d] = wd;
   endtask

   function automatic logic [31:0] expRd(input int d, input logic [31:0] a);
      if (!m_ready[d]) return 32'h0;
      if (zr[d] && a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (in_we[d] && !in_clr[d] && in_wa[d] == a) return in_wd[d];
`endif
      return m_mem[d][a];
   endfunction

   task automatic checkModel();
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < ((d == 0) ? 2 : 4); k++) begin
            logic [31:0] act;
            act = (d == 0) ? rd0[k*32 +: 32] : {24'h0, rd2[k*8 +: 8]};
            checkOutput($sformatf("rd_u%0d_lane%0d", d, k), act, expRd(d, in_ra[d][k]));
         end
         checkOutput($sformatf("ready_u%0d", d), {31'b0, (d == 0) ? ready0 : ready2}, {31'b0, m_ready[d]});
         if (dbg_valid[d])
            checkOutput($sformatf("dbg_u%0d", d), (d == 0) ? dbg0 : {24'h0, dbg2}, m_dbg[d]);
      end
   endtask

   // One rising edge; the model applies the rules to the inputs that were held across it.
   task automatic clockCycle();
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         dbg_valid[d] = mem_known[d];
         m_dbg[d] = (zr[d] && in_dbg[d] == 0) ? 32'h0 : m_mem[d][in_dbg[d]];
         if (!m_ready[d]) begin
            m_mem[d][dep[d] - clear_left[d]] = 32'h0;
            clear_left[d]--;
            if (clear_left[d] == 0) begin
               m_ready[d]   = 1'b1;
               mem_known[d] = 1'b1;
            end
         end else if (in_clr[d]) begin
            m_ready[d]    = 1'b0;
            clear_left[d] = dep[d];
         end else if (in_we[d] && !(zr[d] && in_wa[d] == 0)) begin
            m_mem[d][in_wa[d]] = in_wd[d];
         end
      end
      #1;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         in_we[d]  = 1'b0;
         in_clr[d] = 1'b0;
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         m_ready[d]    = 1'b0;
         clear_left[d] = dep[d];
         m_dbg[d]      = 32'h0;
         dbg_valid[d]  = 1'b1;
      end
      checkModel();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   // Runs 40 edges and reports the edge index at which each ready rose (-1 if it did not).
   task automatic measureSweep(input int clrAt, output int l0, output int l1);
      bit p0, p1;
      l0 = -1;
      l1 = -1;
      p0 = ready0;
      p1 = ready2;
      for (int n = 1; n <= 40; n++) begin
         for (int d = 0; d < 2; d++) begin
            in_we[d] = 1'b0;
            for (int k = 0; k < 4; k++) in_ra[d][k] = $urandom_range(0, dep[d] - 1);
         end
         in_clr[0] = (n == clrAt);
         #1;
         checkModel();
         clockCycle();
         if (ready0 && !p0 && l0 < 0) l0 = n;
         if (ready2 && !p1 && l1 < 0) l1 = n;
         p0 = ready0;
         p1 = ready2;
      end
      in_clr[0] = 1'b0;
   endtask

   initial begin
      int len0, len1;
      logic [7:0] lane_vals [4];

      vecs[0] = '{1'b1,  5, 32'hDEADBEEF,  5,  0, 32'hDEADBEEF, 32'h0};
      vecs[1] = '{1'b1,  5, 32'h00000000,  5,  5, 32'h00000000, 32'h0};
      vecs[2] = '{1'b1,  0, 32'h12345678,  0,  0, 32'h00000000, 32'h0};
      vecs[3] = '{1'b1,  7, 32'h11112222,  7,  5, 32'h11112222, 32'h0};
      vecs[4] = '{1'b1, 31, 32'hFFFFFFFF, 31,  7, 32'hFFFFFFFF, 32'h11112222};
      vecs[5] = '{1'b0,  7, 32'h99999999,  7, 31, 32'h11112222, 32'hFFFFFFFF};

      for (int d = 0; d < 2; d++) begin
         in_we[d] = 1'b0; in_clr[d] = 1'b0; in_wa[d] = 0; in_wd[d] = 0; in_dbg[d] = 0;
         mem_known[d] = 1'b0;
         for (int k = 0; k < 4; k++) in_ra[d][k] = 0;
         for (int a = 0; a < 32; a++) m_mem[d][a] = 32'h0;
      end
      rst_n = 1'b1;
      #1;

      $display("[TB] reset sweep");
      doReset();
      measureSweep(0, len0, len1);
      checkOutput("sweep_len_u0", len0, 32);
      checkOutput("sweep_len_u1", len1, 16);

      for (int a = 0; a < 32; a++) begin
         in_dbg[0] = a;
         clockCycle();
         checkOutput($sformatf("dbg_zero_%0d", a), dbg0, 32'h0);
      end

      $display("[TB] vector table");
      foreach (vecs[i]) begin
         applyStimulus(0, vecs[i].we, vecs[i].wa, vecs[i].wd);
         in_ra[0][0] = vecs[i].ra0;
         in_ra[0][1] = vecs[i].ra1;
         clockCycle();
         in_we[0] = 1'b0;
         #1;
         checkOutput($sformatf("vec%0d_lane0", i), rd0[31:0], vecs[i].e0);
         checkOutput($sformatf("vec%0d_lane1", i), rd0[63:32], vecs[i].e1);
      end

      $display("[TB] bypass");
      applyStimulus(0, 1'b1, 7, 32'h13572468);
      clockCycle();
      applyStimulus(0, 1'b1, 7, 32'hA5A5A5A5);
      in_ra[0][1] = 7;
      #1;
`ifdef REGFILE_BYPASS_EN
      checkOutput("bypass_same_cycle", rd0[63:32], 32'hA5A5A5A5);
`else
      checkOutput("bypass_same_cycle", rd0[63:32], 32'h13572468);
`endif
      clockCycle();
      in_we[0] = 1'b0;
      #1;
      checkOutput("bypass_after_edge", rd0[63:32], 32'hA5A5A5A5);

      $display("[TB] clr priority");
      applyStimulus(0, 1'b1, 3, 32'h0000CAFE);
      clockCycle();
      applyStimulus(0, 1'b1, 3, 32'h00000001);
      in_clr[0]   = 1'b1;
      in_ra[0][0] = 3;
      #1;
      checkOutput("clr_no_bypass", rd0[31:0], 32'h0000CAFE);
      clockCycle();
      in_clr[0] = 1'b0;
      in_we[0]  = 1'b0;
      #1;
      checkOutput("clr_ready_low", {31'b0, ready0}, 32'h0);
      measureSweep(5, len0, len1);
      checkOutput("clr_sweep_len", len0, 32);
      in_ra[0][0] = 3;
      #1;
      checkOutput("clr_entry3", rd0[31:0], 32'h0);

      $display("[TB] reset mid-sweep");
      doReset();
      repeat (10) clockCycle();
      doReset();
      measureSweep(0, len0, len1);
      checkOutput("midreset_len_u0", len0, 32);
      checkOutput("midreset_len_u1", len1, 16);

      $display("[TB] four-lane unit");
      lane_vals = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 1'b1, i, {24'h0, lane_vals[i]});
         clockCycle();
      end
      in_we[1] = 1'b0;
      for (int k = 0; k < 4; k++) in_ra[1][k] = 3 - k;
      #1;
      for (int k = 0; k < 4; k++)
         checkOutput($sformatf("u1_lane%0d", k), {24'h0, rd2[k*8 +: 8]}, {24'h0, lane_vals[3-k]});

      $display("[TB] random traffic");
      for (int n = 0; n < 400; n++) begin
         for (int d = 0; d < 2; d++) begin
            in_we[d]  = 1'($urandom_range(0, 1));
            in_wa[d]  = $urandom_range(0, dep[d] - 1);
            in_wd[d]  = (d == 0) ? $urandom : $urandom_range(0, 255);
            in_clr[d] = ($urandom_range(0, 49) == 0);
            in_dbg[d] = $urandom_range(0, dep[d] - 1);
            for (int k = 0; k < 4; k++) in_ra[d][k] = $urandom_range(0, dep[d] - 1);
            if ($urandom_range(0, 3) == 0) in_ra[d][0] = in_wa[d];
         end
         #1;
         checkModel();
         clockCycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the CPU datapath, replacing the fixed 32×32 two-read-port file. Adds configurable width, depth and read-port count, an optional hardwired-zero entry, and a hardware clear sweep that zeroes every entry after reset or on request. Also adds a registered debug read port for the board-level register viewer. Sits between decode (read addresses) and write-back (write port).

## Interface
- `WIDTH`, 32, data width in bits
- `DEPTH`, 32, number of entries; power of two, at least 2
- `NRD`, 2, number of combinational read ports, 1..4
- `ZERO_REG`, 1, when 1, entry 0 reads as 0 and ignores writes
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ra`  in  NRD*AW  read addresses, packed; port k uses bits [k*AW +: AW], where AW = clog2(DEPTH)
- `rd`  out  NRD*WIDTH  read data, packed the same way
- `we`  in  1  write enable
- `wa`  in  AW  write address
- `wd`  in  WIDTH  write data
- `clr`  in  1  clear request; single-cycle pulse is sufficient
- `ready`  out  1  high when the file is in RUN
- `dbg_addr`  in  AW  debug read address
- `dbg_data`  out  WIDTH  debug read data, registered

## Operation
- FSM states: CLEAR and RUN.
- Reset puts the FSM in CLEAR with the sweep counter at 0.
- **CLEAR**
  - Each cycle writes 0 to entry `cnt`, then increments `cnt`.
  - After entry DEPTH-1 is written, the FSM goes to RUN and `cnt` wraps to 0.
  - `we` and `clr` are ignored.
  - All `rd` lanes read 0.
- **RUN**
  - On a rising edge with `we`=1, `mem[wa]` <= `wd`.
  - Writing the value 0 is a legal write and must update the entry.
  - When ZERO_REG=1, a write with `wa`=0 is dropped.
- **clr in RUN**
  - `clr`=1 moves the FSM to CLEAR on the next edge.
  - `clr` has priority: a `we` in the same cycle is dropped.
- **Reads**
  - `rd` lane k = `mem[ra_k]`, combinational.
  - When ZERO_REG=1 and `ra_k`=0, lane k reads 0.
- **Debug port**
  - `dbg_data` <= `mem[dbg_addr]` every cycle, including during CLEAR. It shows partially cleared contents there.
  - ZERO_REG masking applies to the debug port too.
- Memory array has no asynchronous reset; the sweep clears it.

## Timing
- **Reset values:** `ready`=0, `dbg_data`=0, every `rd` lane = 0 (masked because `ready`=0).
- **Clear duration:** after `rst_n` deasserts, CLEAR lasts exactly DEPTH cycles. `ready` rises on the edge that writes entry DEPTH-1. The first accepted write is the next edge after that.
- **Write-to-read latency:** without bypass, a write is visible on `rd` one edge later. With bypass, see Configuration.
- **Debug latency:** one cycle from `dbg_addr` to `dbg_data`.
- **Simultaneous accesses:** any number of read lanes may address the same entry or the write address in the same cycle, with no hazard.
- **Reset mid-sweep:** asserting `rst_n` low restarts the sweep at 0, and the full DEPTH-cycle clear repeats.
- **`clr` during CLEAR:** ignored; no restart.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- **Defined:** in RUN, if `we`=1 and `ra_k`==`wa` and the write is not dropped (ZERO_REG, `clr`), lane k returns `wd` in the same cycle. The debug port does not bypass.
- **Undefined:** lane k returns the old `mem[ra_k]` until the edge.

## Structure
- Package `regfile_pkg`:
  - `typedef enum logic [0:0] {RF_CLEAR, RF_RUN} rf_state_t`
  - `function automatic int rf_aw(int depth)` returning clog2
  - default-parameter constants
- One sub-module, `regfile_clear_fsm`: owns the state and sweep counter, and outputs `ready`, `sweep_we` and `sweep_addr`.
- Memory, read mux and bypass stay in the top module.

## Test plan
- **Reset sweep:** assert `rst_n` low, release; count cycles → `ready` rises after exactly 32 cycles. All `rd` read 0 beforehand; `dbg_data` reads 0 for all 32 addresses afterwards.
- **Zero write:** write 0xDEADBEEF to entry 5, then write 0 to entry 5 → `rd` lane 0 (`ra`=5) reads 0x00000000.
- **Zero register:** ZERO_REG=1, write 0x12345678 to entry 0 → both lanes with `ra`=0 read 0.
- **Bypass:** `we`=1, `wa`=7, `wd`=0xA5A5A5A5, `ra` lane 1=7, same cycle → lane 1 reads 0xA5A5A5A5 with `REGFILE_BYPASS_EN` defined, and the old value without it.
- **clr priority:** pulse `clr` together with `we` to entry 3 (0x1) → the write is lost, `ready` falls for 32 cycles, and entry 3 reads 0 afterwards.
- **Reset mid-sweep:** drop `rst_n` at sweep cycle 10 → `ready` rises exactly 32 cycles after the release. Parameter sweep: DEPTH=16, NRD=4, WIDTH=8 → 16-cycle clear, four independent lanes correct.
